// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 4-digit active-low 7-segment bus and decodes each digit back to BCD.
// A digit is captured once per stable period after its anode/segment pattern settles.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] bcd_out,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        err,
  output logic [1:0]  err_digit,
  output logic        stale
);

  localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [23:0] TIMEOUT_MAX = 24'(TIMEOUT_CYCLES);
  localparam logic [1:0]  K_INVALID   = 2'd0;
  localparam logic [1:0]  K_DIGIT     = 2'd1;
  localparam logic [1:0]  K_BLANK     = 2'd2;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  // Returns {kind, value}; inverse of the active-low encoder table (bit 0 = a).
  function automatic logic [5:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'h40:   decode_seg = {K_DIGIT, 4'd0};
      7'h79:   decode_seg = {K_DIGIT, 4'd1};
      7'h24:   decode_seg = {K_DIGIT, 4'd2};
      7'h30:   decode_seg = {K_DIGIT, 4'd3};
      7'h19:   decode_seg = {K_DIGIT, 4'd4};
      7'h12:   decode_seg = {K_DIGIT, 4'd5};
      7'h02:   decode_seg = {K_DIGIT, 4'd6};
      7'h78:   decode_seg = {K_DIGIT, 4'd7};
      7'h00:   decode_seg = {K_DIGIT, 4'd8};
      7'h10:   decode_seg = {K_DIGIT, 4'd9};
      7'h7F:   decode_seg = {K_BLANK, 4'hF};
      default: decode_seg = {K_INVALID, 4'h0};
    endcase
  endfunction

  logic [3:0]  s_an_q, s_an_d, prev_an_q, prev_an_d;
  logic [6:0]  s_seg_q, s_seg_d, prev_seg_q, prev_seg_d;
  state_t      state_q, state_d;
  logic [7:0]  stab_q, stab_d;
  logic [3:0]  bm_q, bm_d;
  logic [23:0] to_q, to_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  valid_q, valid_d;
  logic        fd_q, fd_d, err_q, err_d, stale_q, stale_d;
  logic [1:0]  err_digit_q, err_digit_d;

  logic        changed, active, capture;
  logic [1:0]  sel;
  logic [5:0]  dec;

  always_comb begin
    active = 1'b1;
    sel    = 2'd0;
    case (s_an_q)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: active = 1'b0;
    endcase
  end

  assign changed = ({s_an_q, s_seg_q} != {prev_an_q, prev_seg_q});
  assign dec     = decode_seg(s_seg_q);

  always_comb begin
    s_an_d      = an_in;
    s_seg_d     = seg_in;
    prev_an_d   = s_an_q;
    prev_seg_d  = s_seg_q;
    state_d     = state_q;
    stab_d      = stab_q;
    bcd_d       = bcd_q;
    valid_d     = valid_q;
    err_d       = err_q;
    err_digit_d = err_digit_q;
    capture     = 1'b0;

    case (state_q)
      IDLE: begin
        if (active) begin
          state_d = SETTLE;
          stab_d  = 8'd1;
        end
      end
      SETTLE: begin
        if (changed) begin
          state_d = active ? SETTLE : IDLE;
          stab_d  = active ? 8'd1 : 8'd0;
        end else if (stab_q >= STABLE_MAX) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (stab_q != 8'hFF) begin
          stab_d = stab_q + 8'd1;
        end
      end
      HOLD: begin
        if (changed) begin
          state_d = active ? SETTLE : IDLE;
          stab_d  = active ? 8'd1 : 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    // The full bitmap is retired one cycle after it fills; a capture that cycle seeds the next frame.
    fd_d = (bm_q == 4'hF);
    bm_d = fd_d ? 4'h0 : bm_q;

    for (int i = 0; i < 4; i++) begin
      if (capture && sel == 2'(i)) begin
        case (dec[5:4])
          K_DIGIT: begin
            bcd_d[4*i +: 4] = dec[3:0];
            valid_d[i]      = 1'b1;
          end
          K_BLANK: begin
            bcd_d[4*i +: 4] = 4'hF;
            valid_d[i]      = 1'b0;
          end
          default: begin
            valid_d[i]  = 1'b0;
            err_d       = 1'b1;
            err_digit_d = sel;
          end
        endcase
        bm_d[i] = 1'b1;
      end
    end

    if (capture)                 to_d = 24'd0;
    else if (to_q < TIMEOUT_MAX) to_d = to_q + 24'd1;
    else                         to_d = to_q;
    stale_d = (to_d == TIMEOUT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_an_q      <= 4'hF;
      s_seg_q     <= 7'h7F;
      prev_an_q   <= 4'hF;
      prev_seg_q  <= 7'h7F;
      state_q     <= IDLE;
      stab_q      <= 8'd0;
      bm_q        <= 4'h0;
      to_q        <= 24'd0;
      bcd_q       <= 16'h0;
      valid_q     <= 4'h0;
      fd_q        <= 1'b0;
      err_q       <= 1'b0;
      err_digit_q <= 2'd0;
      stale_q     <= 1'b0;
    end else begin
      s_an_q      <= s_an_d;
      s_seg_q     <= s_seg_d;
      prev_an_q   <= prev_an_d;
      prev_seg_q  <= prev_seg_d;
      state_q     <= state_d;
      stab_q      <= stab_d;
      bm_q        <= bm_d;
      to_q        <= to_d;
      bcd_q       <= bcd_d;
      valid_q     <= valid_d;
      fd_q        <= fd_d;
      err_q       <= err_d;
      err_digit_q <= err_digit_d;
      stale_q     <= stale_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_valid = valid_q;
  assign frame_done  = fd_q;
  assign err         = err_q;
  assign err_digit   = err_digit_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios followed by random scanning,
// every cycle compared against a run-length reference model of the display bus.
module tb_seg7_scan_decoder;

  localparam int S = 4;
  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] bcd_out;
  logic [3:0]  digit_valid;
  logic        frame_done, err, stale;
  logic [1:0]  err_digit;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .bcd_out(bcd_out), .digit_valid(digit_valid), .frame_done(frame_done),
    .err(err), .err_digit(err_digit), .stale(stale)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state
  logic [15:0] e_bcd;
  logic [3:0]  e_valid, m_set;
  logic        e_fd, e_err, e_stale, m_pend;
  logic [1:0]  e_errd;
  int          e_to, m_run, m_idx;
  logic [10:0] m_last;
  logic [6:0]  m_pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_bcd = 16'h0; e_valid = 4'h0; e_fd = 1'b0; e_err = 1'b0; e_errd = 2'd0;
    e_to = 0; e_stale = 1'b0; m_set = 4'h0; m_last = {4'hF, 7'h7F};
    m_run = 0; m_pend = 1'b0; m_idx = 0; m_pat = 7'h7F;
  endtask

  // One clock edge: apply the capture decided last edge, then log the new bus sample.
  task automatic model_edge(input logic [3:0] an, input logic [6:0] seg);
    int v, zeros, idx;
    e_fd = (m_set == 4'hF);
    if (e_fd) m_set = 4'h0;
    if (m_pend) begin
      v = -1;
      for (int k = 0; k < 10; k++) if (codes[k] == m_pat) v = k;
      if (v >= 0) begin
        e_bcd[m_idx*4 +: 4] = 4'(v);
        e_valid[m_idx] = 1'b1;
      end else if (m_pat == 7'h7F) begin
        e_bcd[m_idx*4 +: 4] = 4'hF;
        e_valid[m_idx] = 1'b0;
      end else begin
        e_valid[m_idx] = 1'b0;
        e_err = 1'b1;
        e_errd = 2'(m_idx);
      end
      m_set[m_idx] = 1'b1;
      e_to = 0;
    end else if (e_to < T) begin
      e_to++;
    end
    e_stale = (e_to == T);
    if ({an, seg} == m_last) m_run++;
    else m_run = 1;
    m_last = {an, seg};
    zeros = 0;
    idx = 0;
    for (int k = 0; k < 4; k++) if (!an[k]) begin zeros++; idx = k; end
    m_pend = (m_run == S + 1) && (zeros == 1);
    m_idx = idx;
    m_pat = seg;
  endtask

  task automatic check_all();
    chk("bcd_out", 32'(bcd_out), 32'(e_bcd));
    chk("digit_valid", 32'(digit_valid), 32'(e_valid));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("err", 32'(err), 32'(e_err));
    chk("err_digit", 32'(err_digit), 32'(e_errd));
    chk("stale", 32'(stale), 32'(e_stale));
  endtask

  task automatic cyc(input logic [3:0] an, input logic [6:0] seg);
    an_in = an;
    seg_in = seg;
    @(posedge clk);
    if (rst_n) model_edge(an, seg);
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'h0);
    chk({tag, "_valid"}, 32'(digit_valid), 32'h0);
    chk({tag, "_fd"}, 32'(frame_done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_errd"}, 32'(err_digit), 32'h0);
    chk({tag, "_stale"}, 32'(stale), 32'h0);
  endtask

  initial begin
    int fd_cnt;
    logic [15:0] saved;
    logic [6:0] scan_pat [4];
    logic [3:0] ran;
    logic [6:0] rseg;
    int len, r;

    scan_pat = '{7'h79, 7'h24, 7'h30, 7'h19};
    rst_n = 1'b0;
    an_in = 4'hF;
    seg_in = 7'h7F;
    model_reset();
    #2;
    chk_reset_vals("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Timeout with no active anode
    for (int c = 0; c < T - 1; c++) cyc(4'hF, 7'h7F);
    chk("stale_before", 32'(stale), 32'h0);
    cyc(4'hF, 7'h7F);
    chk("stale_at_T", 32'(stale), 32'h1);

    // Scan "1234" onto digits 3..0
    fd_cnt = 0;
    for (int d = 3; d >= 0; d--) begin
      for (int c = 0; c < 8; c++) begin
        cyc(~(4'b0001 << d), scan_pat[3-d]);
        if (frame_done) fd_cnt++;
        if (d == 3 && c == 4) chk("stale_hold", 32'(stale), 32'h1);
        if (d == 3 && c == 5) begin
          chk("stale_clear", 32'(stale), 32'h0);
          chk("dig3_cap", 32'(bcd_out[15:12]), 32'h1);
        end
      end
    end
    chk("scan_bcd", 32'(bcd_out), 32'h1234);
    chk("scan_valid", 32'(digit_valid), 32'hF);
    chk("scan_err", 32'(err), 32'h0);
    chk("scan_frames", 32'(fd_cnt), 32'h1);

    // Glitching segments on digit 0, then stable "7"
    for (int c = 0; c < 10; c++) begin
      cyc(4'b1110, ((c / 2) % 2 == 0) ? 7'h79 : 7'h24);
      chk("glitch_hold", 32'(bcd_out[3:0]), 32'h4);
    end
    for (int c = 0; c < 6; c++) begin
      cyc(4'b1110, 7'h78);
      if (c == 4) chk("seven_early", 32'(bcd_out[3:0]), 32'h4);
      if (c == 5) chk("seven_cap", 32'(bcd_out[3:0]), 32'h7);
    end

    // Undecodable pattern on digit 2
    for (int c = 0; c < 8; c++) cyc(4'b1011, 7'h36);
    chk("inv_err", 32'(err), 32'h1);
    chk("inv_errd", 32'(err_digit), 32'h2);
    chk("inv_bcd", 32'(bcd_out[11:8]), 32'h2);
    chk("inv_valid", 32'(digit_valid[2]), 32'h0);

    // Blank on digit 3
    for (int c = 0; c < 8; c++) cyc(4'b0111, 7'h7F);
    chk("blank_bcd", 32'(bcd_out[15:12]), 32'hF);
    chk("blank_valid", 32'(digit_valid[3]), 32'h0);
    chk("blank_err", 32'(err), 32'h1);

    // Two anodes active: nothing captured
    saved = bcd_out;
    for (int c = 0; c < 10; c++) cyc(4'b1100, 7'h30);
    chk("two_an_bcd", 32'(bcd_out), 32'(saved));

    // Reset in the middle of a settling period
    for (int c = 0; c < 3; c++) cyc(4'b1101, 7'h19);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    model_reset();
    cyc(4'b1101, 7'h19);
    cyc(4'b1101, 7'h19);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) cyc(4'hF, 7'h7F);

    // Random scanning against the model
    for (int seg_i = 0; seg_i < 90; seg_i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) ran = ~(4'b0001 << $urandom_range(0, 3));
      else if (r < 85) ran = 4'hF;
      else ran = 4'($urandom);
      r = $urandom_range(0, 99);
      if (r < 60) rseg = codes[$urandom_range(0, 9)];
      else if (r < 75) rseg = 7'h7F;
      else rseg = 7'($urandom);
      len = $urandom_range(1, 9);
      for (int c = 0; c < len; c++) cyc(ran, rseg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
